// File: rtl/mem_resp_credit_arb_if.sv
// Purpose: bundles the requester, memory-port and response-FIFO signals of the credit arbiter.
// Latency: none, plain wiring.
// Backpressure: carries the valid/ready and req/gnt handshakes; the arbiter drives the slave side.
interface mem_resp_credit_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int DEPTH   = 8
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic               flush_i;
    logic [NUM_REQ-1:0] req_valid_i;
    logic [NUM_REQ-1:0] req_ready_o;
    logic               mem_req_o;
    logic               mem_gnt_i;
    logic [IDX_W-1:0]   mem_idx_o;
    logic               fifo_pop_i;
    logic [CNT_W-1:0]   credit_o;
    logic [IDX_W-1:0]   resp_idx_o;
    logic               resp_idx_valid_o;
    logic               err_o;

    modport slave (
        input  flush_i, req_valid_i, mem_gnt_i, fifo_pop_i,
        output req_ready_o, mem_req_o, mem_idx_o, credit_o, resp_idx_o, resp_idx_valid_o, err_o
    );

    modport master (
        output flush_i, req_valid_i, mem_gnt_i, fifo_pop_i,
        input  req_ready_o, mem_req_o, mem_idx_o, credit_o, resp_idx_o, resp_idx_valid_o, err_o
    );
endinterface

// File: rtl/mem_resp_credit_arb.sv
// Purpose: round-robin arbiter for one memory port, gated by response-FIFO credits, tracking response owners in order.
// Latency: request presented combinationally in the same cycle; owner index visible the cycle after the grant.
// Backpressure: a presented-but-ungranted winner is held until granted; issue stalls when all DEPTH slots are outstanding.
module mem_resp_credit_arb #(
    parameter int NUM_REQ = 4,
    parameter int DEPTH   = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    mem_resp_credit_arb_if.slave  bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_REQ  = IDX_W'(NUM_REQ - 1);
    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(DEPTH - 1);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] hold_idx_q, hold_idx_d;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] arb_win;
    logic [IDX_W-1:0] mem_idx;
    logic [CNT_W-1:0] outstanding_q;
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [IDX_W-1:0] idx_mem [DEPTH];
    logic             mem_req;
    logic             hs;
    logic             pop_ok;
    logic             empty;

    // Pick the first valid requester at or above the round-robin pointer.
    always_comb begin : arb_search
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        logic             found;
        cand     = 0;
        cand_idx = '0;
        found    = 1'b0;
        arb_win  = ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand     = (int'(ptr_q) + k) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!found && bus.req_valid_i[cand_idx]) begin
                arb_win = cand_idx;
                found   = 1'b1;
            end
        end
    end

    // Handshake, credit gating and response pop qualification; reset forces the request low.
    always_comb begin
        empty   = (outstanding_q == '0);
        mem_idx = (state_q == HOLD) ? hold_idx_q : arb_win;
        mem_req = rst_ni && !bus.flush_i && (outstanding_q < DEPTH_C)
                  && ((state_q == HOLD) || (|bus.req_valid_i));
        hs      = mem_req && bus.mem_gnt_i;
        pop_ok  = bus.fifo_pop_i && !empty && !bus.flush_i;
        bus.req_ready_o = '0;
        if (hs) begin
            bus.req_ready_o[mem_idx] = 1'b1;
        end
    end

    assign bus.mem_req_o        = mem_req;
    assign bus.mem_idx_o        = mem_idx;
    assign bus.credit_o         = DEPTH_C - outstanding_q;
    assign bus.resp_idx_valid_o = !empty;
    assign bus.resp_idx_o       = empty ? '0 : idx_mem[rd_q];
    assign bus.err_o            = rst_ni && bus.fifo_pop_i && empty && !bus.flush_i;

    // Hold state: freeze the winner once it is presented but not yet granted.
    always_comb begin
        state_d    = state_q;
        hold_idx_d = hold_idx_q;
        case (state_q)
            IDLE: begin
                if (mem_req && !bus.mem_gnt_i) begin
                    state_d    = HOLD;
                    hold_idx_d = mem_idx;
                end
            end
            HOLD: begin
                if (hs || bus.flush_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            hold_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_idx_q <= hold_idx_d;
        end
    end

    // Round-robin pointer moves past the winner only on an accepted request; flush leaves it alone.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (hs) begin
            ptr_q <= (mem_idx == LAST_REQ) ? '0 : mem_idx + 1'b1;
        end
    end

    // Outstanding count and owner-queue pointers; flush discards everything in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
            wr_q          <= '0;
            rd_q          <= '0;
        end else if (bus.flush_i) begin
            outstanding_q <= '0;
            wr_q          <= '0;
            rd_q          <= '0;
        end else begin
            if (hs && !pop_ok) begin
                outstanding_q <= outstanding_q + 1'b1;
            end else if (!hs && pop_ok) begin
                outstanding_q <= outstanding_q - 1'b1;
            end
            if (hs) begin
                wr_q <= (wr_q == LAST_SLOT) ? '0 : wr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_q <= (rd_q == LAST_SLOT) ? '0 : rd_q + 1'b1;
            end
        end
    end

    // Owner storage; contents only matter while the count says they are live.
    always_ff @(posedge clk_i) begin
        if (hs) begin
            idx_mem[wr_q] <= mem_idx;
        end
    end
endmodule

// File: tb/tb_mem_resp_credit_arb.sv
// Purpose: self-checking bench for mem_resp_credit_arb (directed table, corner sequences, random vs. model).
// Latency: inputs applied 1 ns after the rising edge, outputs sampled on the falling edge.
// Backpressure: memory grant and response pops are randomised against a queue-based model.
module tb_mem_resp_credit_arb;
    localparam int NR = 4;
    localparam int DP = 8;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    always #5 clk_i = ~clk_i;

    mem_resp_credit_arb_if #(.NUM_REQ(NR), .DEPTH(DP)) bus ();

    mem_resp_credit_arb #(.NUM_REQ(NR), .DEPTH(DP)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0] v;
        logic       g;
        logic       p;
        logic       f;
        logic       req;
        logic [1:0] idx;
        logic [3:0] rdy;
        logic [3:0] cr;
        logic       err;
        logic       rv;
    } vec_t;

    vec_t tbl [16];

    // reference model state
    int q[$];
    int m_ptr;
    bit m_pend;
    int m_pidx;

    function automatic vec_t mk(input logic [3:0] v, input logic g, input logic p, input logic f,
                                input logic req, input logic [1:0] idx, input logic [3:0] rdy,
                                input logic [3:0] cr, input logic err, input logic rv);
        vec_t t;
        t.v = v; t.g = g; t.p = p; t.f = f;
        t.req = req; t.idx = idx; t.rdy = rdy; t.cr = cr; t.err = err; t.rv = rv;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic g, input logic p, input logic f);
        @(posedge clk_i);
        #1;
        bus.req_valid_i = v;
        bus.mem_gnt_i   = g;
        bus.fifo_pop_i  = p;
        bus.flush_i     = f;
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_ni          = 1'b0;
        bus.req_valid_i = '0;
        bus.mem_gnt_i   = 1'b0;
        bus.fifo_pop_i  = 1'b0;
        bus.flush_i     = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        q.delete();
        m_ptr  = 0;
        m_pend = 0;
        m_pidx = 0;
    endtask

    // Compare one sampled cycle against the model, then advance the model past the clock edge.
    task automatic model_cycle(input logic [3:0] v, input logic g, input logic p, input logic f, input int cyc);
        bit e_req, hs, e_err;
        int widx, c;
        bit found;
        logic [3:0] e_rdy;
        e_req = (m_pend || v != 0) && (q.size() < DP) && !f;
        widx  = m_ptr;
        found = 0;
        if (m_pend) begin
            widx = m_pidx;
        end else begin
            for (int k = 0; k < NR; k++) begin
                c = (m_ptr + k) % NR;
                if (!found && v[c]) begin
                    widx  = c;
                    found = 1;
                end
            end
        end
        hs    = e_req && g;
        e_rdy = hs ? (4'b0001 << widx) : 4'b0000;
        e_err = p && (q.size() == 0) && !f;
        chk($sformatf("rnd%0d.mem_req", cyc), 32'(bus.mem_req_o), 32'(e_req));
        chk($sformatf("rnd%0d.mem_idx", cyc), 32'(bus.mem_idx_o), 32'(widx));
        chk($sformatf("rnd%0d.ready", cyc), 32'(bus.req_ready_o), 32'(e_rdy));
        chk($sformatf("rnd%0d.credit", cyc), 32'(bus.credit_o), 32'(DP - q.size()));
        chk($sformatf("rnd%0d.resp_vld", cyc), 32'(bus.resp_idx_valid_o), 32'(q.size() != 0));
        chk($sformatf("rnd%0d.resp_idx", cyc), 32'(bus.resp_idx_o), 32'((q.size() != 0) ? q[0] : 0));
        chk($sformatf("rnd%0d.err", cyc), 32'(bus.err_o), 32'(e_err));
        if (f) begin
            q.delete();
            m_pend = 0;
        end else begin
            if (p && q.size() != 0) void'(q.pop_front());
            if (hs) begin
                q.push_back(widx);
                m_ptr  = (widx + 1) % NR;
                m_pend = 0;
            end else if (e_req) begin
                m_pend = 1;
                m_pidx = widx;
            end
        end
    endtask

    initial begin
        // all-valid stream to full, pop/issue collision, flush, empty pop
        tbl[0]  = mk(4'hF, 1, 0, 0, 1, 0, 4'b0001, 8, 0, 0);
        tbl[1]  = mk(4'hF, 1, 0, 0, 1, 1, 4'b0010, 7, 0, 1);
        tbl[2]  = mk(4'hF, 1, 0, 0, 1, 2, 4'b0100, 6, 0, 1);
        tbl[3]  = mk(4'hF, 1, 0, 0, 1, 3, 4'b1000, 5, 0, 1);
        tbl[4]  = mk(4'hF, 1, 0, 0, 1, 0, 4'b0001, 4, 0, 1);
        tbl[5]  = mk(4'hF, 1, 0, 0, 1, 1, 4'b0010, 3, 0, 1);
        tbl[6]  = mk(4'hF, 1, 0, 0, 1, 2, 4'b0100, 2, 0, 1);
        tbl[7]  = mk(4'hF, 1, 0, 0, 1, 3, 4'b1000, 1, 0, 1);
        tbl[8]  = mk(4'hF, 1, 0, 0, 0, 0, 4'b0000, 0, 0, 1);
        tbl[9]  = mk(4'hF, 1, 1, 0, 0, 0, 4'b0000, 0, 0, 1);
        tbl[10] = mk(4'hF, 1, 0, 0, 1, 0, 4'b0001, 1, 0, 1);
        tbl[11] = mk(4'hF, 1, 0, 0, 0, 1, 4'b0000, 0, 0, 1);
        tbl[12] = mk(4'hF, 1, 1, 1, 0, 1, 4'b0000, 0, 0, 1);
        tbl[13] = mk(4'h0, 0, 0, 0, 0, 1, 4'b0000, 8, 0, 0);
        tbl[14] = mk(4'h0, 0, 1, 0, 0, 1, 4'b0000, 8, 1, 0);
        tbl[15] = mk(4'h0, 0, 0, 0, 0, 1, 4'b0000, 8, 0, 0);

        // reset state
        do_reset();
        chk("rst.credit", 32'(bus.credit_o), 32'(DP));
        chk("rst.resp_vld", 32'(bus.resp_idx_valid_o), 0);
        chk("rst.err", 32'(bus.err_o), 0);

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].v, tbl[i].g, tbl[i].p, tbl[i].f);
            chk($sformatf("t%0d.mem_req", i), 32'(bus.mem_req_o), 32'(tbl[i].req));
            chk($sformatf("t%0d.mem_idx", i), 32'(bus.mem_idx_o), 32'(tbl[i].idx));
            chk($sformatf("t%0d.ready", i), 32'(bus.req_ready_o), 32'(tbl[i].rdy));
            chk($sformatf("t%0d.credit", i), 32'(bus.credit_o), 32'(tbl[i].cr));
            chk($sformatf("t%0d.err", i), 32'(bus.err_o), 32'(tbl[i].err));
            chk($sformatf("t%0d.resp_vld", i), 32'(bus.resp_idx_valid_o), 32'(tbl[i].rv));
        end

        // held winner survives its own valid dropping
        do_reset();
        drive(4'b0110, 0, 0, 0);
        chk("hold1.idx", 32'(bus.mem_idx_o), 1);
        chk("hold1.ready", 32'(bus.req_ready_o), 0);
        drive(4'b0100, 0, 0, 0);
        chk("hold2.idx", 32'(bus.mem_idx_o), 1);
        chk("hold2.req", 32'(bus.mem_req_o), 1);
        chk("hold2.ready", 32'(bus.req_ready_o), 0);
        drive(4'b0100, 0, 0, 0);
        chk("hold3.idx", 32'(bus.mem_idx_o), 1);
        chk("hold3.ready", 32'(bus.req_ready_o), 0);
        drive(4'b0100, 1, 0, 0);
        chk("hold4.idx", 32'(bus.mem_idx_o), 1);
        chk("hold4.ready", 32'(bus.req_ready_o), 32'(4'b0010));
        drive(4'b0000, 0, 0, 0);
        chk("hold5.req", 32'(bus.mem_req_o), 0);
        chk("hold5.ptr", 32'(bus.mem_idx_o), 2);
        chk("hold5.credit", 32'(bus.credit_o), 7);

        // response owners come back in grant order
        do_reset();
        drive(4'b0100, 1, 0, 0);
        chk("ord.g2", 32'(bus.req_ready_o), 32'(4'b0100));
        drive(4'b0001, 1, 0, 0);
        chk("ord.g0", 32'(bus.req_ready_o), 32'(4'b0001));
        drive(4'b1000, 1, 0, 0);
        chk("ord.g3", 32'(bus.req_ready_o), 32'(4'b1000));
        drive(4'b0000, 0, 1, 0);
        chk("ord.r0", 32'(bus.resp_idx_o), 2);
        drive(4'b0000, 0, 1, 0);
        chk("ord.r1", 32'(bus.resp_idx_o), 0);
        drive(4'b0000, 0, 1, 0);
        chk("ord.r2", 32'(bus.resp_idx_o), 3);
        chk("ord.r2vld", 32'(bus.resp_idx_valid_o), 1);
        drive(4'b0000, 0, 0, 0);
        chk("ord.end_vld", 32'(bus.resp_idx_valid_o), 0);
        chk("ord.end_credit", 32'(bus.credit_o), 8);

        // asynchronous reset while a request is held
        do_reset();
        drive(4'b0001, 1, 0, 0);
        drive(4'b0010, 0, 0, 0);
        chk("arst.pre_req", 32'(bus.mem_req_o), 1);
        chk("arst.pre_credit", 32'(bus.credit_o), 7);
        @(posedge clk_i);
        #2;
        rst_ni         = 1'b0;
        bus.mem_gnt_i  = 1'b1;
        bus.fifo_pop_i = 1'b1;
        #1;
        chk("arst.req", 32'(bus.mem_req_o), 0);
        chk("arst.ready", 32'(bus.req_ready_o), 0);
        chk("arst.credit", 32'(bus.credit_o), 8);
        chk("arst.resp_vld", 32'(bus.resp_idx_valid_o), 0);
        chk("arst.resp_idx", 32'(bus.resp_idx_o), 0);
        chk("arst.err", 32'(bus.err_o), 0);
        @(negedge clk_i);
        bus.req_valid_i = '0;
        bus.mem_gnt_i   = 1'b0;
        bus.fifo_pop_i  = 1'b0;
        rst_ni          = 1'b1;
        drive(4'b0000, 0, 0, 0);
        chk("arst.post_credit", 32'(bus.credit_o), 8);
        chk("arst.post_ptr", 32'(bus.mem_idx_o), 0);

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] v;
            logic g, p, f;
            int pth;
            pth = ((i / 400) % 2 == 1) ? 7 : 3;
            v = 4'($urandom_range(0, 15));
            g = ($urandom_range(0, 9) < 7);
            p = ($urandom_range(0, 9) < pth);
            f = ($urandom_range(0, 99) < 3);
            drive(v, g, p, f);
            model_cycle(v, g, p, f, i);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_resp_credit_arb.md
MEM_RESP_CREDIT_ARB -- requirements
Module: mem_resp_credit_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing one memory port and its response FIFO.
REQ-002 SHALL have parameter DEPTH, default 8: depth of the downstream response stream FIFO; sets the credit pool size.
REQ-003 SHALL have derived parameter IDX_W = (NUM_REQ > 1 ? $clog2(NUM_REQ) : 1) and CNT_W = $clog2(DEPTH+1).
REQ-004 SHALL use one clock; reset is asynchronous and active-low; ports named clk_i and rst_ni.
REQ-005 clk_i  input  1  clock, all state on rising edge.
REQ-006 rst_ni  input  1  asynchronous active-low reset.
REQ-007 flush_i  input  1  synchronous flush, same cycle as the FIFO's flush_i.
REQ-008 req_valid_i  input  NUM_REQ  per-requester request valid.
REQ-009 req_ready_o  output  NUM_REQ  per-requester accept, one-hot or zero.
REQ-010 mem_req_o  output  1  request to memory port.
REQ-011 mem_gnt_i  input  1  memory grant; handshake = mem_req_o & mem_gnt_i.
REQ-012 mem_idx_o  output  IDX_W  index of requester currently presented.
REQ-013 fifo_pop_i  input  1  response FIFO pop (FIFO valid_o & ready_i).
REQ-014 credit_o  output  CNT_W  free response slots = DEPTH - outstanding.
REQ-015 resp_idx_o  output  IDX_W  requester owning the oldest outstanding response.
REQ-016 resp_idx_valid_o  output  1  high when outstanding != 0.
REQ-017 err_o  output  1  one-cycle pulse on pop with nothing outstanding.

Function
REQ-018 SHALL keep outstanding counter (0..DEPTH); issue permitted only when outstanding < DEPTH.
REQ-019 SHALL round-robin arbitrate: winner = first i with req_valid_i[i] searching from pointer upward modulo NUM_REQ.
REQ-020 SHALL advance pointer to (winner+1) mod NUM_REQ only on handshake; pointer unchanged otherwise, including flush.
REQ-021 SHALL implement FSM IDLE/HOLD: IDLE -> HOLD when mem_req_o high and mem_gnt_i low; HOLD -> IDLE on handshake or flush.
REQ-022 SHALL, in HOLD, present the latched winner regardless of other valids (no re-arbitration until granted).
REQ-023 SHALL drive mem_req_o combinationally = (HOLD or any valid) & outstanding < DEPTH & ~flush_i; mem_idx_o = latched winner in HOLD, else arbiter winner.
REQ-024 SHALL assert req_ready_o[mem_idx_o] only in the handshake cycle; all other bits 0.
REQ-025 SHALL push mem_idx_o into an internal DEPTH-entry index queue on handshake; pop it on fifo_pop_i when outstanding != 0.
REQ-026 SHALL on simultaneous handshake and valid pop keep outstanding unchanged and push+pop the queue in the same cycle (legal at outstanding == DEPTH? no: handshake blocked at DEPTH, pop frees next cycle).
REQ-027 SHALL ignore fifo_pop_i when outstanding == 0 and pulse err_o for that cycle.
REQ-028 SHALL on flush_i clear outstanding, queue pointers, FSM to IDLE; flush wins over handshake and pop in the same cycle; err_o not asserted during flush.
REQ-029 SHALL wrap queue read/write pointers modulo DEPTH; DEPTH non-power-of-two supported.

Reset
REQ-030 SHALL on rst_ni low asynchronously set: outstanding 0, credit_o DEPTH, pointer 0, FSM IDLE, queue empty, err_o 0, resp_idx_o 0, resp_idx_valid_o 0.
REQ-031 SHALL, while in reset, hold mem_req_o and req_ready_o at 0 regardless of inputs.
REQ-032 SHALL on reset mid-HOLD drop the pending request; the lost handshake is not counted.

Verification
REQ-033 NUM_REQ=4, valid=4'b1111, gnt always 1, no pops -> grants 0,1,2,3,0..., stop after 8 handshakes, credit_o=0, mem_req_o=0.
REQ-034 valid=4'b0110, gnt low 3 cycles then high, valid[1] dropped meanwhile -> mem_idx_o stays 1 all 4 cycles, ready_o=4'b0010 on cycle 4 only.
REQ-035 DEPTH=8 full, pop and new request same cycle -> no issue that cycle, issue next cycle, credit_o 0->1->0.
REQ-036 grants to 2,0,3 then three pops -> resp_idx_o sequence 2,0,3; resp_idx_valid_o low after third pop.
REQ-037 outstanding=5, flush_i with simultaneous handshake and pop -> next cycle credit_o=8, FSM IDLE, err_o 0, pointer unchanged.
REQ-038 pop with outstanding=0 -> err_o single-cycle pulse, credit_o stays 8; async reset asserted mid-HOLD -> outputs at reset values immediately.
